// File: rtl/latency_ram.sv
// -----------------------------------------------------------------------------
// latency_ram
//
// Word-addressed 32-bit data memory that answers the Memory unit's RAM strobe
// interface. Each accepted read or write completes after a fixed LATENCY, and
// a one-cycle status pulse reports the completion.
//
// Ports
//   clk          in   1   system clock, rising-edge
//   nRST         in   1   asynchronous active-low reset
//   address      in  32   byte address; word index = address[ADDR_BITS+1:2]
//   writeData    in  32   store data, captured with the request
//   nRD          in   1   active-low read request strobe
//   nWR          in   1   active-low write request strobe
//   Dataout      out 32   last completed read value (0 after reset)
//   readStatus   out  1   one-cycle pulse: read complete, Dataout valid
//   writeStatus  out  1   one-cycle pulse: write committed
//   isLastState  out  1   high during the final BUSY cycle
//   o_dbg_state  out  2   current FSM state (0 IDLE, 1 BUSY, 2 DONE)
//
// Handshake: in IDLE, a low nRD or nWR sampled on a rising edge is a request
// and is accepted on that edge (there is no back-pressure signal; the
// requester must wait for the status pulse). Strobes are ignored in BUSY and
// DONE. Completion is signalled by exactly one of readStatus/writeStatus for
// one cycle; the next request can be accepted on the edge that follows.
// -----------------------------------------------------------------------------
module latency_ram #(
  parameter int LATENCY   = 10,
  parameter int ADDR_BITS = 8
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  input  logic        nRD,
  input  logic        nWR,
  output logic [31:0] Dataout,
  output logic        readStatus,
  output logic        writeStatus,
  output logic        isLastState,
  output logic [1:0]  o_dbg_state
);

  localparam int              CW       = $clog2(LATENCY + 1);
  localparam logic [CW-1:0]   LAST_CNT = CW'(LATENCY);
  localparam int              DEPTH    = 2 ** ADDR_BITS;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [CW-1:0]         r_count;
  logic [CW-1:0]         w_next_count;
  logic [ADDR_BITS-1:0]  r_idx;
  logic [31:0]           r_wdata;
  logic                  r_is_rd;
  logic [31:0]           r_dataout;
  logic                  r_read_status;
  logic                  r_write_status;
  logic [31:0]           r_mem [DEPTH];

  logic                  w_accept;
  logic                  w_complete;
  logic                  w_is_last;
  logic                  w_unused_addr_bits;

  // Byte-lane and high address bits carry no meaning for this memory.
  assign w_unused_addr_bits = &{address[31:ADDR_BITS+2], address[1:0]};

  // r_count is the 1-based index of the current BUSY cycle, so BUSY lasts
  // exactly LATENCY cycles and the last of them is the one with
  // r_count == LATENCY. Completion happens on the edge that ends it.
  always_comb begin
    w_next_state = r_state;
    w_next_count = r_count;
    w_accept     = 1'b0;
    w_complete   = 1'b0;
    w_is_last    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!nRD || !nWR) begin
          w_accept     = 1'b1;
          w_next_state = ST_BUSY;
          w_next_count = CW'(1);
        end
      end
      ST_BUSY: begin
        w_is_last = (r_count == LAST_CNT);
        if (w_is_last) begin
          w_complete   = 1'b1;
          w_next_state = ST_DONE;
          w_next_count = '0;
        end else begin
          w_next_count = r_count + CW'(1);
        end
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_count = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_state <= ST_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_next_state;
      r_count <= w_next_count;
    end
  end

  // Operands are captured only on acceptance and held through BUSY.
  // A simultaneous nRD/nWR request is a read; the write is dropped.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_idx   <= '0;
      r_wdata <= '0;
      r_is_rd <= 1'b0;
    end else if (w_accept) begin
      r_idx   <= address[ADDR_BITS+1:2];
      r_wdata <= writeData;
      r_is_rd <= !nRD;
    end
  end

  // Status bits are recomputed every edge, so each is high only in DONE.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_read_status  <= 1'b0;
      r_write_status <= 1'b0;
      r_dataout      <= '0;
    end else begin
      r_read_status  <= w_complete && r_is_rd;
      r_write_status <= w_complete && !r_is_rd;
      if (w_complete && r_is_rd) begin
        r_dataout <= r_mem[r_idx];
      end
    end
  end

  // The array has no reset. A reset during BUSY drops r_state to IDLE at
  // once, so w_complete never fires and a pending write is not committed.
  always_ff @(posedge clk) begin
    if (w_complete && !r_is_rd) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  assign Dataout     = r_dataout;
  assign readStatus  = r_read_status;
  assign writeStatus = r_write_status;
  assign isLastState = w_is_last;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_latency_ram.sv
module tb_latency_ram;

  localparam int LATENCY   = 10;
  localparam int ADDR_BITS = 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic        clk;
  logic        nRST;
  logic [31:0] address;
  logic [31:0] writeData;
  logic        nRD;
  logic        nWR;
  logic [31:0] Dataout;
  logic        readStatus;
  logic        writeStatus;
  logic        isLastState;
  logic [1:0]  o_dbg_state;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] model_mem [int];
  logic [31:0] exp_dout;

  latency_ram #(
    .LATENCY   (LATENCY),
    .ADDR_BITS (ADDR_BITS)
  ) dut (
    .clk         (clk),
    .nRST        (nRST),
    .address     (address),
    .writeData   (writeData),
    .nRD         (nRD),
    .nWR         (nWR),
    .Dataout     (Dataout),
    .readStatus  (readStatus),
    .writeStatus (writeStatus),
    .isLastState (isLastState),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------------------------------------------------------- clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- checker
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------- driver
  // Called at a falling edge while the DUT is IDLE. Drives one request for a
  // single edge, then checks every cycle from E0 through the return to IDLE.
  // inj_j >= 0 drives a stray write (addr 0x20, data 0x1234) in cycle inj_j,
  // which the DUT must ignore.
  task automatic txn(input logic rd, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input int inj_j);
    logic        is_read;
    logic        is_write;
    int          idx;
    logic [31:0] rd_val;
    logic [1:0]  exp_state;
    is_read  = rd;
    is_write = wr && !rd;
    idx      = int'(addr[ADDR_BITS+1:2]);
    rd_val   = '0;
    nRD       = !rd;
    nWR       = !wr;
    address   = addr;
    writeData = wdata;
    if (is_read) begin
      rd_val = model_mem[idx];
      exp_q.push_back(rd_val);
    end else if (is_write) begin
      model_mem[idx] = wdata;
    end
    @(posedge clk);   // E0
    @(negedge clk);
    nRD       = 1'b1;
    nWR       = 1'b1;
    address   = $urandom;
    writeData = $urandom;
    for (int j = 0; j <= LATENCY + 1; j++) begin
      if (j < LATENCY)       exp_state = S_BUSY;
      else if (j == LATENCY) exp_state = S_DONE;
      else                   exp_state = S_IDLE;
      if (j == LATENCY && is_read) exp_dout = rd_val;
      check($sformatf("state_c%0d", j), 32'(o_dbg_state), 32'(exp_state));
      check($sformatf("is_last_c%0d", j), 32'(isLastState), 32'(j == LATENCY - 1));
      check($sformatf("rd_status_c%0d", j), 32'(readStatus), 32'(is_read && j == LATENCY));
      check($sformatf("wr_status_c%0d", j), 32'(writeStatus), 32'(is_write && j == LATENCY));
      check($sformatf("dataout_c%0d", j), Dataout, exp_dout);
      if (readStatus === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_unexpected_read", 32'(exp_q.size()), 32'd1);
        end else begin
          check("scoreboard_read_data", Dataout, exp_q.pop_front());
        end
      end
      if (j == inj_j) begin
        nWR       = 1'b0;
        address   = 32'h20;
        writeData = 32'h1234;
      end else begin
        nWR = 1'b1;
      end
      if (j < LATENCY + 1) @(negedge clk);
    end
    nWR = 1'b1;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int          ridx;
    logic [31:0] raddr;
    logic [31:0] rdata;

    nRST      = 1'b0;
    nRD       = 1'b1;
    nWR       = 1'b1;
    address   = '0;
    writeData = '0;
    exp_dout  = '0;
    #1;
    check("reset_dataout", Dataout, 32'h0);
    check("reset_rd_status", 32'(readStatus), 32'd0);
    check("reset_wr_status", 32'(writeStatus), 32'd0);
    check("reset_is_last", 32'(isLastState), 32'd0);
    check("reset_state", 32'(o_dbg_state), 32'(S_IDLE));
    repeat (2) @(negedge clk);
    nRST = 1'b1;
    @(negedge clk);

    // Known contents for the locations the ignored/aborted writes target.
    txn(1'b0, 1'b1, 32'h20, 32'h0000_2020, -1);
    txn(1'b0, 1'b1, 32'h30, 32'h0000_3030, -1);

    // Write then read back through the latency pipeline.
    txn(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, -1);
    txn(1'b1, 1'b0, 32'h10, 32'h0, -1);

    // Stray write during BUSY, then during DONE: both ignored.
    txn(1'b1, 1'b0, 32'h10, 32'h0, 3);
    txn(1'b1, 1'b0, 32'h20, 32'h0, -1);
    txn(1'b1, 1'b0, 32'h30, 32'h0, LATENCY);
    txn(1'b1, 1'b0, 32'h20, 32'h0, -1);

    // Both strobes low: read wins, the write is dropped.
    txn(1'b1, 1'b1, 32'h10, 32'h5, -1);
    txn(1'b1, 1'b0, 32'h10, 32'h0, -1);

    // Reset in the middle of a write aborts it.
    nWR       = 1'b0;
    address   = 32'h30;
    writeData = 32'hAA;
    @(posedge clk);
    @(negedge clk);
    nWR = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    nRST = 1'b0;
    #1;
    exp_dout = '0;
    check("abort_dataout", Dataout, 32'h0);
    check("abort_rd_status", 32'(readStatus), 32'd0);
    check("abort_wr_status", 32'(writeStatus), 32'd0);
    check("abort_is_last", 32'(isLastState), 32'd0);
    check("abort_state", 32'(o_dbg_state), 32'(S_IDLE));
    @(negedge clk);
    nRST = 1'b1;
    for (int k = 0; k < LATENCY + 2; k++) begin
      @(negedge clk);
      check($sformatf("abort_no_wr_status_c%0d", k), 32'(writeStatus), 32'd0);
      check($sformatf("abort_idle_c%0d", k), 32'(o_dbg_state), 32'(S_IDLE));
    end
    txn(1'b1, 1'b0, 32'h30, 32'h0, -1);

    // High address bits alias onto the same word.
    txn(1'b0, 1'b1, 32'h400, 32'h77, -1);
    txn(1'b1, 1'b0, 32'h000, 32'h0, -1);

    // Random write/read pairs in the upper part of the array.
    for (int n = 0; n < 3; n++) begin
      ridx  = int'($urandom_range(64, 255));
      rdata = $urandom;
      raddr = ($urandom & 32'hFFFF_FC00) | (32'(ridx) << 2) | 32'($urandom_range(0, 3));
      txn(1'b0, 1'b1, raddr, rdata, -1);
      raddr = ($urandom & 32'hFFFF_FC00) | (32'(ridx) << 2);
      txn(1'b1, 1'b0, raddr, 32'h0, -1);
    end

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
